// File: rtl/fifo_flex_ram.sv
// Storage array for fifo_flex: WIDTH x 2^ABITS entries.
// Synchronous write port, asynchronous (combinational) read port.
module fifo_flex_ram #(
   parameter int WIDTH = 64,
   parameter int ABITS = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ABITS-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [ABITS-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ABITS;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Synchronous single-clock FIFO with optional registered output stage.
// Capacity is DEPTH + REG_OUT; level and flags cover storage plus output register.
module fifo_flex #(
   parameter int WIDTH    = 64,
   parameter int ABITS    = 2,
   parameter int REG_OUT  = 0,
   parameter int AF_LEVEL = (1 << ABITS) + REG_OUT - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   output logic             a_almost_full,
   output logic             a_full,
   output logic [WIDTH-1:0] b_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic             b_almost_empty,
   output logic [ABITS:0]   level
);

   localparam int DEPTH = 1 << ABITS;
   localparam int CAP   = DEPTH + REG_OUT;

   localparam logic [ABITS:0] CAP_V = (ABITS + 1)'(CAP);
   localparam logic [ABITS:0] AF_V  = (ABITS + 1)'(AF_LEVEL);
   localparam logic [ABITS:0] AE_V  = (ABITS + 1)'(AE_LEVEL);

   if (ABITS < 1 || REG_OUT < 0 || REG_OUT > 1 ||
       AF_LEVEL < 1 || AF_LEVEL > CAP || AE_LEVEL < 0 || AE_LEVEL >= CAP) begin : g_param_check
      $error("fifo_flex: illegal parameter combination");
   end

   logic [ABITS-1:0] wr_ptr;
   logic [ABITS-1:0] rd_ptr;
   logic [ABITS:0]   level_q;
   logic             wr_en;
   logic             rd_en;
   logic             mem_we;
   logic             mem_rd;
   logic [WIDTH-1:0] mem_rdata;

   assign level          = level_q;
   assign a_full         = (level_q == CAP_V);
   assign a_almost_full  = (level_q >= AF_V);
   assign b_almost_empty = (level_q <= AE_V);
   assign a_ready        = !rst && !flush && !a_full;
   assign wr_en          = a_valid && a_ready;
   assign rd_en          = b_valid && b_ready;

   fifo_flex_ram #(
      .WIDTH (WIDTH),
      .ABITS (ABITS)
   ) u_ram (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (a_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   if (REG_OUT == 0) begin : g_direct
      assign b_valid = (level_q != '0) && !flush;
      assign b_data  = mem_rdata;
      assign mem_we  = wr_en;
      assign mem_rd  = rd_en;
   end else begin : g_regout
      logic             out_vld;
      logic [WIDTH-1:0] out_data;
      logic [ABITS:0]   stored;
      logic             stor_empty;
      logic             load;
      logic             bypass;

      // Invariant: the output register is valid whenever storage holds anything,
      // so storage occupancy is simply level minus the output register.
      assign stored     = level_q - {{ABITS{1'b0}}, out_vld};
      assign stor_empty = (stored == '0);
      assign load       = !out_vld || rd_en;
      assign bypass     = load && stor_empty && wr_en;
      assign mem_we     = wr_en && !bypass;
      assign mem_rd     = load && !stor_empty;
      assign b_valid    = out_vld && !flush;
      assign b_data     = out_data;

      always_ff @(posedge clk) begin
         if (rst || flush) begin
            out_vld <= 1'b0;
         end else if (load) begin
            out_vld <= !stor_empty || wr_en;
         end
      end

      // Data path carries no reset; contents are don't-care while out_vld is low.
      always_ff @(posedge clk) begin
         if (load) begin
            out_data <= stor_empty ? a_data : mem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (mem_we) wr_ptr <= wr_ptr + 1'b1;
         if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: one instance per output mode, vector tables,
// directed corner sequences and randomized traffic against a queue model.
module tb_fifo_flex;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst     [2];
   logic       flush   [2];
   logic       a_valid [2];
   logic       b_ready [2];
   logic [7:0] a_data  [2];
   logic       a_ready [2];
   logic       a_af    [2];
   logic       a_full  [2];
   logic       b_valid [2];
   logic       b_ae    [2];
   logic [7:0] b_data  [2];
   logic [2:0] level   [2];

   fifo_flex #(.WIDTH(8), .ABITS(2), .REG_OUT(0)) dut0 (
      .clk(clk), .rst(rst[0]), .flush(flush[0]), .a_data(a_data[0]), .a_valid(a_valid[0]),
      .a_ready(a_ready[0]), .a_almost_full(a_af[0]), .a_full(a_full[0]), .b_data(b_data[0]),
      .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_almost_empty(b_ae[0]), .level(level[0]));

   fifo_flex #(.WIDTH(8), .ABITS(2), .REG_OUT(1)) dut1 (
      .clk(clk), .rst(rst[1]), .flush(flush[1]), .a_data(a_data[1]), .a_valid(a_valid[1]),
      .a_ready(a_ready[1]), .a_almost_full(a_af[1]), .a_full(a_full[1]), .b_data(b_data[1]),
      .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_almost_empty(b_ae[1]), .level(level[1]));

   int tests = 0;
   int fails = 0;

   // Reference model: per-instance ring of accepted words (capacity 4 or 5).
   int         cap    [2] = '{4, 5};
   int         af_lv  [2] = '{3, 4};
   logic [7:0] mbuf   [2][8];
   int         mhead  [2] = '{0, 0};
   int         mcnt   [2] = '{0, 0};

   typedef struct {
      int         m;
      bit         av;
      logic [7:0] ad;
      bit         br;
      logic [2:0] lv;
      bit         bv;
      logic [7:0] bd;
      bit         ar;
      bit         fu;
      bit         af;
      bit         ae;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[m%0d] @%0t: got %0h expected %0h", nm, m, $time, act, exp);
      end
   endtask

   task automatic model_check(input int m);
      bit ev;
      ev = (mcnt[m] != 0) && !flush[m];
      chk("model_level", m, 32'(level[m]), 32'(mcnt[m]));
      chk("model_b_valid", m, 32'(b_valid[m]), 32'(ev));
      if (ev) chk("model_b_data", m, 32'(b_data[m]), 32'(mbuf[m][mhead[m]]));
      chk("model_a_ready", m, 32'(a_ready[m]), 32'(!rst[m] && !flush[m] && mcnt[m] < cap[m]));
      chk("model_a_full", m, 32'(a_full[m]), 32'(mcnt[m] == cap[m]));
      chk("model_almost_full", m, 32'(a_af[m]), 32'(mcnt[m] >= af_lv[m]));
      chk("model_almost_empty", m, 32'(b_ae[m]), 32'(mcnt[m] <= 1));
   endtask

   task automatic model_update(input int m);
      bit w;
      bit r;
      if (rst[m] || flush[m]) begin
         mcnt[m]  = 0;
         mhead[m] = 0;
      end else begin
         w = a_valid[m] && (mcnt[m] < cap[m]);
         r = b_ready[m] && (mcnt[m] != 0);
         if (r) begin
            mhead[m] = (mhead[m] + 1) % 8;
            mcnt[m]--;
         end
         if (w) begin
            mbuf[m][(mhead[m] + mcnt[m]) % 8] = a_data[m];
            mcnt[m]++;
         end
      end
   endtask

   // Called just after a falling edge: model checks, then advance one clock.
   task automatic settle();
      model_check(0);
      model_check(1);
      @(posedge clk);
      model_update(0);
      model_update(1);
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      settle();
   endtask

   task automatic idle(input int m);
      rst[m]     = 1'b0;
      flush[m]   = 1'b0;
      a_valid[m] = 1'b0;
      b_ready[m] = 1'b0;
      a_data[m]  = 8'h00;
   endtask

   task automatic add(input int m, input bit av, input logic [7:0] ad, input bit br,
                      input logic [2:0] lv, input bit bv, input logic [7:0] bd,
                      input bit ar, input bit fu, input bit af, input bit ae);
      vec_t v;
      v.m = m; v.av = av; v.ad = ad; v.br = br; v.lv = lv; v.bv = bv; v.bd = bd;
      v.ar = ar; v.fu = fu; v.af = af; v.ae = ae;
      tbl.push_back(v);
   endtask

   task automatic write_n(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         for (int m = 0; m < 2; m++) begin
            idle(m);
            a_valid[m] = 1'b1;
            a_data[m]  = base + 8'(i);
         end
         tick();
      end
      idle(0);
      idle(1);
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) begin
         b_ready[0] = 1'b1;
         b_ready[1] = 1'b1;
         tick();
      end
      idle(0);
      idle(1);
   endtask

   initial begin
      // Mode 0 fill/drain: m av data br | level bv bdata ar full af ae
      add(0, 1, 8'h11, 0, 3'd0, 0, 8'h00, 1, 0, 0, 1);
      add(0, 1, 8'h22, 0, 3'd1, 1, 8'h11, 1, 0, 0, 1);
      add(0, 1, 8'h33, 0, 3'd2, 1, 8'h11, 1, 0, 0, 0);
      add(0, 1, 8'h44, 0, 3'd3, 1, 8'h11, 1, 0, 1, 0);
      add(0, 1, 8'h55, 0, 3'd4, 1, 8'h11, 0, 1, 1, 0);
      add(0, 0, 8'h00, 1, 3'd4, 1, 8'h11, 0, 1, 1, 0);
      add(0, 0, 8'h00, 1, 3'd3, 1, 8'h22, 1, 0, 1, 0);
      add(0, 0, 8'h00, 1, 3'd2, 1, 8'h33, 1, 0, 0, 0);
      add(0, 0, 8'h00, 1, 3'd1, 1, 8'h44, 1, 0, 0, 1);
      add(0, 0, 8'h00, 0, 3'd0, 0, 8'h00, 1, 0, 0, 1);
      // Mode 1 fill/drain: capacity five
      add(1, 1, 8'h01, 0, 3'd0, 0, 8'h00, 1, 0, 0, 1);
      add(1, 1, 8'h02, 0, 3'd1, 1, 8'h01, 1, 0, 0, 1);
      add(1, 1, 8'h03, 0, 3'd2, 1, 8'h01, 1, 0, 0, 0);
      add(1, 1, 8'h04, 0, 3'd3, 1, 8'h01, 1, 0, 0, 0);
      add(1, 1, 8'h05, 0, 3'd4, 1, 8'h01, 1, 0, 1, 0);
      add(1, 1, 8'h06, 0, 3'd5, 1, 8'h01, 0, 1, 1, 0);
      add(1, 0, 8'h00, 1, 3'd5, 1, 8'h01, 0, 1, 1, 0);
      add(1, 0, 8'h00, 1, 3'd4, 1, 8'h02, 1, 0, 1, 0);
      add(1, 0, 8'h00, 1, 3'd3, 1, 8'h03, 1, 0, 0, 0);
      add(1, 0, 8'h00, 1, 3'd2, 1, 8'h04, 1, 0, 0, 0);
      add(1, 0, 8'h00, 1, 3'd1, 1, 8'h05, 1, 0, 0, 1);
      add(1, 0, 8'h00, 0, 3'd0, 0, 8'h00, 1, 0, 0, 1);

      // Reset both instances
      for (int m = 0; m < 2; m++) begin
         idle(m);
         rst[m] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) idle(m);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("reset_level", m, 32'(level[m]), 32'd0);
         chk("reset_b_valid", m, 32'(b_valid[m]), 32'd0);
         chk("reset_a_full", m, 32'(a_full[m]), 32'd0);
         chk("reset_almost_full", m, 32'(a_af[m]), 32'd0);
         chk("reset_almost_empty", m, 32'(b_ae[m]), 32'd1);
      end
      settle();

      // Vector tables
      foreach (tbl[i]) begin
         idle(0);
         idle(1);
         a_valid[tbl[i].m] = tbl[i].av;
         a_data[tbl[i].m]  = tbl[i].ad;
         b_ready[tbl[i].m] = tbl[i].br;
         @(negedge clk);
         chk("tbl_level", tbl[i].m, 32'(level[tbl[i].m]), 32'(tbl[i].lv));
         chk("tbl_b_valid", tbl[i].m, 32'(b_valid[tbl[i].m]), 32'(tbl[i].bv));
         if (tbl[i].bv) chk("tbl_b_data", tbl[i].m, 32'(b_data[tbl[i].m]), 32'(tbl[i].bd));
         chk("tbl_a_ready", tbl[i].m, 32'(a_ready[tbl[i].m]), 32'(tbl[i].ar));
         chk("tbl_a_full", tbl[i].m, 32'(a_full[tbl[i].m]), 32'(tbl[i].fu));
         chk("tbl_almost_full", tbl[i].m, 32'(a_af[tbl[i].m]), 32'(tbl[i].af));
         chk("tbl_almost_empty", tbl[i].m, 32'(b_ae[tbl[i].m]), 32'(tbl[i].ae));
         settle();
      end
      idle(0);
      idle(1);

      // Write into empty FIFO is visible the following cycle
      write_n(1, 8'hA5);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("empty_write_b_valid", m, 32'(b_valid[m]), 32'd1);
         chk("empty_write_b_data", m, 32'(b_data[m]), 32'hA5);
      end
      settle();
      drain();

      // Steady simultaneous read/write at level 2 across pointer wrap
      write_n(2, 8'h10);
      for (int i = 0; i < 10; i++) begin
         for (int m = 0; m < 2; m++) begin
            a_valid[m] = 1'b1;
            b_ready[m] = 1'b1;
            a_data[m]  = 8'h12 + 8'(i);
         end
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            chk("stream_level", m, 32'(level[m]), 32'd2);
            chk("stream_b_data", m, 32'(b_data[m]), 32'h10 + 32'(i));
         end
         settle();
      end
      idle(0);
      idle(1);
      drain();

      // Flush at level 3, then a single entry round trip
      write_n(3, 8'h30);
      for (int m = 0; m < 2; m++) begin
         flush[m]   = 1'b1;
         a_valid[m] = 1'b1;
         a_data[m]  = 8'hEE;
         b_ready[m] = 1'b1;
      end
      tick();
      idle(0);
      idle(1);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("flush_level", m, 32'(level[m]), 32'd0);
         chk("flush_b_valid", m, 32'(b_valid[m]), 32'd0);
         chk("flush_almost_empty", m, 32'(b_ae[m]), 32'd1);
      end
      settle();
      write_n(1, 8'h5A);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("post_flush_b_data", m, 32'(b_data[m]), 32'h5A);
         chk("post_flush_level", m, 32'(level[m]), 32'd1);
      end
      settle();
      drain();

      // Reset mid-stream with handshakes pending
      write_n(3, 8'h40);
      for (int m = 0; m < 2; m++) begin
         rst[m]     = 1'b1;
         a_valid[m] = 1'b1;
         b_ready[m] = 1'b1;
         a_data[m]  = 8'h77;
      end
      tick();
      idle(0);
      idle(1);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("midrst_level", m, 32'(level[m]), 32'd0);
         chk("midrst_b_valid", m, 32'(b_valid[m]), 32'd0);
         chk("midrst_a_full", m, 32'(a_full[m]), 32'd0);
         chk("midrst_almost_full", m, 32'(a_af[m]), 32'd0);
         chk("midrst_almost_empty", m, 32'(b_ae[m]), 32'd1);
      end
      settle();
      write_n(1, 8'h99);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("post_rst_b_data", m, 32'(b_data[m]), 32'h99);
      end
      settle();
      drain();

      // Randomized traffic with varying read/write pressure
      for (int seg = 0; seg < 4; seg++) begin
         for (int c = 0; c < 200; c++) begin
            for (int m = 0; m < 2; m++) begin
               a_valid[m] = ($urandom_range(0, 3) < 3 - seg / 2);
               b_ready[m] = ($urandom_range(0, 3) < 1 + seg / 2 + seg % 2);
               a_data[m]  = 8'($urandom);
               flush[m]   = ($urandom_range(0, 49) == 0);
               rst[m]     = ($urandom_range(0, 119) == 0);
            end
            tick();
         end
      end
      idle(0);
      idle(1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 Parameter WIDTH, default 64, data width in bits.
REQ-002 Parameter ABITS, default 2, storage address bits; DEPTH = 2^ABITS entries.
REQ-003 Parameter REG_OUT, default 0; 1 adds a registered output stage, so capacity CAP = DEPTH + REG_OUT.
REQ-004 Parameter AF_LEVEL, default CAP-1, almost-full threshold.
REQ-005 Parameter AE_LEVEL, default 1, almost-empty threshold.
REQ-006 Reset is synchronous and active-high; design uses one clock.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 flush  input  1  synchronous clear of contents.
REQ-010 a_data  input  WIDTH  write data.
REQ-011 a_valid  input  1  write request.
REQ-012 a_ready  output  1  write accepted when a_valid & a_ready.
REQ-013 a_almost_full  output  1  level >= AF_LEVEL.
REQ-014 a_full  output  1  level == CAP.
REQ-015 b_data  output  WIDTH  read data, meaningful while b_valid.
REQ-016 b_valid  output  1  entry available.
REQ-017 b_ready  input  1  read taken when b_valid & b_ready.
REQ-018 b_almost_empty  output  1  level <= AE_LEVEL.
REQ-019 level  output  ABITS+1  current occupancy, 0..CAP.

Function
REQ-020 Full CAP entries shall be usable; a_ready = !rst & !flush & !a_full.
REQ-021 b_valid = (level != 0) & !flush; data emerges in strict write order.
REQ-022 A write accepted in cycle N shall make that entry visible on b_valid/b_data in cycle N+1 in both modes, including when the FIFO is empty.
REQ-023 REG_OUT=0: b_data is an asynchronous read of the storage entry at rd_ptr.
REQ-024 REG_OUT=1: b_data comes from the output register; when the register is empty or being consumed, it loads the head of storage, or the incoming write directly when storage is empty.
REQ-025 Simultaneous accepted write and read shall leave level unchanged; write-only increments and read-only decrements level by 1.
REQ-026 When full, a_ready = 0 even if b_ready = 1 in the same cycle; no pass-through.
REQ-027 wr_ptr and rd_ptr shall wrap modulo DEPTH with no gap or skipped entry.
REQ-028 flush shall, next cycle, set level = 0, empty the output register and reset the pointers; no handshake occurs in the flush cycle.
REQ-029 Elaboration shall fail unless ABITS >= 1, 1 <= AF_LEVEL <= CAP, and 0 <= AE_LEVEL < CAP.

Reset
REQ-030 In the cycle after rst is sampled high: level = 0, b_valid = 0, a_full = 0, a_almost_full = (AF_LEVEL == 0), b_almost_empty = 1, and the pointers and output-register valid are cleared.
REQ-031 While rst is high, a_ready = 0 and no write or read takes effect.
REQ-032 Storage contents are not reset; b_data is don't-care while b_valid = 0.
REQ-033 rst shall take precedence over flush and over any handshake.

Structure
REQ-034 No shared package; DEPTH and CAP are local constants.
REQ-035 Storage shall be one sub-module, fifo_flex_ram: synchronous write, asynchronous read, WIDTH x DEPTH.
REQ-036 The output stage and the level/flag logic reside in fifo_flex.

Verification (WIDTH=8, ABITS=2)
REQ-037 REG_OUT=0, b_ready=0, write 0x11,0x22,0x33,0x44 back-to-back -> level=4, a_full=1, a_ready=0, a_almost_full from 3rd write; drain yields 0x11,0x22,0x33,0x44.
REQ-038 REG_OUT=1, write 0x01..0x05 with b_ready=0 -> a_full only after 5th, level=5; drain yields 0x01..0x05.
REQ-039 Empty FIFO, write 0xA5 in cycle N -> b_valid=1, b_data=0xA5 at N+1, both modes.
REQ-040 Level 2, a_valid=b_ready=1 for 10 cycles with incrementing data -> level stays 2, output sequence in order across pointer wrap.
REQ-041 Level 3, flush for one cycle -> next cycle level=0, b_valid=0, b_almost_empty=1; write 0x5A then accepted and read back as the only entry.
REQ-042 Level 3, rst mid-stream with a_valid=b_ready=1 -> the REQ-030 reset values appear next cycle and pre-reset data never appears on b_data with b_valid=1.
